// File: rtl/mem_bridge.sv
// mem_bridge: valid/ready memory-access unit between the multicycle core and a variable-latency port.
// Define MEM_BRIDGE_TIMEOUT_EN to build the REQ/RESP watchdog that abandons a stuck transaction.
module mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic              c_unsigned,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_done,
    output logic              c_err,
    output logic              busy,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W/8-1:0] m_be,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_valid;
    logic              r_we;
    logic              r_done;
    logic              r_err;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [NB-1:0]     r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [OB-1:0]     r_off;
    logic [1:0]        r_size;

    logic [OB-1:0]     w_off;
    logic              w_misaligned;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_timeout;

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz);
        return ~({NB{1'b1}} << (1 << sz));
    endfunction

    function automatic logic [DATA_W-1:0] data_mask(input logic [1:0] sz);
        return ~({DATA_W{1'b1}} << (8 << sz));
    endfunction

    function automatic logic is_misaligned(input logic [OB-1:0] off, input logic [1:0] sz);
        return ((off & OB'((1 << sz) - 1)) != '0) || (sz == 2'd3 && DATA_W < 64);
    endfunction

    // Keep the low 2^sz bytes and fill the rest with the sign bit or zero.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d,
                                                      input logic [1:0] sz,
                                                      input logic uns);
        logic [DATA_W-1:0] keep;
        logic [DATA_W-1:0] top;
        logic              s;
        keep = data_mask(sz);
        top  = {{(DATA_W-1){1'b0}}, 1'b1} << ((8 << sz) - 1);
        s    = ~uns & (|(d & top));
        return (d & keep) | ({DATA_W{s}} & ~keep);
    endfunction

    assign w_off        = c_addr[OB-1:0];
    assign w_misaligned = is_misaligned(w_off, c_size);
    assign w_be         = lane_mask(c_size) << w_off;
    assign w_wdata      = (c_wdata & data_mask(c_size)) << {w_off, 3'b000};
    assign w_rdata      = extend_load(m_rdata >> {r_off, 3'b000}, r_size, r_uns);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 256) ? 8 : 16;
    logic [CNT_W-1:0] r_cnt;

    // Idle clears the count, so it starts from zero on every entry to REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (r_state == IDLE)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    // Without the watchdog TIMEOUT has no effect; the compare is constant false.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_off   <= '0;
            r_size  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (c_req) begin
                        if (w_misaligned) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_state <= REQ;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b1;
                            r_we    <= c_we;
                            r_addr  <= {c_addr[ADDR_W-1:OB], {OB{1'b0}}};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_off   <= w_off;
                            r_size  <= c_size;
                            r_uns   <= c_unsigned;
                        end
                    end
                end
                REQ: begin
                    if (m_ready) begin
                        r_valid <= 1'b0;
                        if (r_we) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RESP;
                        end
                    end else if (w_timeout) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (m_rvalid) begin
                        r_rdata <= w_rdata;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign c_rdata = r_rdata;
    assign c_done  = r_done;
    assign c_err   = r_err;
    assign busy    = r_busy;
    assign m_valid = r_valid;
    assign m_we    = r_we;
    assign m_addr  = r_addr;
    assign m_be    = r_be;
    assign m_wdata = r_wdata;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: scoreboard bench for mem_bridge (DATA_W=32); completion results are queued at issue
// and popped when c_done pulses. Timeout scenarios run when MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_mem_bridge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int LONG_STALL = 3;
`else
    localparam int TB_TIMEOUT = 255;
    localparam int LONG_STALL = 5;
`endif

    logic              clk;
    logic              rst;
    logic              c_req;
    logic              c_we;
    logic [1:0]        c_size;
    logic              c_unsigned;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_done;
    logic              c_err;
    logic              busy;
    logic              m_valid;
    logic              m_ready;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_be;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_last;
    int          n_vec;
    int          n_err;

    mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_unsigned(c_unsigned),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata),
        .c_done(c_done), .c_err(c_err), .busy(busy),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
        .m_be(m_be), .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor: every c_done must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (c_err) check("err_needs_done", c_done, 1);
            if (c_done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", c_done, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_err", c_err, e.err);
                    check("done_rdata", c_rdata, e.rdata);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic err, input logic [31:0] rd);
        exp_t e;
        c_req = 1'b1; c_we = we; c_size = sz; c_unsigned = uns; c_addr = addr; c_wdata = wd;
        if (!err && !we) exp_last = rd;
        e.err = err;
        e.rdata = exp_last;
        sb.push_back(e);
        @(posedge clk); #1;
        c_req = 1'b0;
        c_we = 1'($urandom); c_size = 2'($urandom); c_unsigned = 1'($urandom);
        c_addr = $urandom; c_wdata = $urandom;
    endtask

    task automatic check_req(input string tag, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_we"}, m_we, we);
        check({tag, "_addr"}, m_addr, addr);
        check({tag, "_be"}, m_be, be);
        check({tag, "_wdata"}, m_wdata, wd);
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                          input int stall, input logic [31:0] rd, input int rlat,
                          input logic [31:0] erd);
        issue(we, sz, uns, addr, wd, 1'b0, erd);
        m_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check_req({tag, "_stall"}, we, ea, ebe, ewd);
            @(posedge clk); #1;
        end
        check_req(tag, we, ea, ebe, ewd);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        if (we) begin
            check({tag, "_wr_done"}, c_done, 1);
            check({tag, "_wr_idle"}, busy, 0);
        end else begin
            check({tag, "_rd_vdrop"}, m_valid, 0);
            check({tag, "_rd_busy"}, busy, 1);
            for (int i = 1; i < rlat; i++) begin
                @(posedge clk); #1;
                check({tag, "_rd_wait"}, c_done, 0);
            end
            m_rvalid = 1'b1; m_rdata = rd;
            @(posedge clk); #1;
            m_rvalid = 1'b0; m_rdata = $urandom;
            check({tag, "_rd_done"}, c_done, 1);
            check({tag, "_rd_idle"}, busy, 0);
        end
    endtask

    task automatic misaligned(input string tag, input logic we, input logic [1:0] sz,
                              input logic [31:0] addr);
        issue(we, sz, 1'b0, addr, 32'h5555_5555, 1'b1, 32'h0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, c_done, 1);
        check({tag, "_err"}, c_err, 1);
        @(posedge clk); #1;
        check({tag, "_done_clr"}, c_done, 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_last = '0;
        rst = 1'b1; c_req = 0; c_we = 0; c_size = 0; c_unsigned = 0; c_addr = 0; c_wdata = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = 0;
        #12;
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", c_rdata, 0);
        check("rst_done", c_done, 0);
        check("rst_addr", m_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // m_rvalid in IDLE must not complete anything
        m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        check("idle_rvalid_done", c_done, 0);
        check("idle_rvalid_rdata", c_rdata, 0);

        access("sb_store", 1, 2'd0, 0, 32'h0000_0103, 32'h1234_56AB,
               32'h0000_0100, 4'b1000, 32'hAB00_0000, 0, 0, 0, 0);
        access("lh_signed", 0, 2'd1, 0, 32'h0000_0202, 32'h0,
               32'h0000_0200, 4'b1100, 32'h0, 0, 32'h8001_1234, 3, 32'hFFFF_8001);
        access("lbu", 0, 2'd0, 1, 32'h0000_0203, 32'h0,
               32'h0000_0200, 4'b1000, 32'h0, 1, 32'h8001_1234, 3, 32'h0000_0080);
        access("lb_signed", 0, 2'd0, 0, 32'h0000_0201, 32'h0,
               32'h0000_0200, 4'b0010, 32'h0, 0, 32'h8001_F234, 2, 32'hFFFF_FFF2);
        access("lw", 0, 2'd2, 0, 32'h0000_0300, 32'h0,
               32'h0000_0300, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        access("lhu", 0, 2'd1, 1, 32'h0000_0200, 32'h0,
               32'h0000_0200, 4'b0011, 32'h0, 0, 32'h1234_8765, 2, 32'h0000_8765);
        // back-to-back: the second store is sampled on the edge where c_done is high
        access("sh_store", 1, 2'd1, 0, 32'h0000_000A, 32'hCAFE_BEEF,
               32'h0000_0008, 4'b1100, 32'hBEEF_0000, 0, 0, 0, 0);
        access("b2b_store", 1, 2'd0, 0, 32'h0000_0011, 32'h0000_0077,
               32'h0000_0010, 4'b0010, 32'h0000_7700, 0, 0, 0, 0);

        misaligned("mis_word", 0, 2'd2, 32'h0000_0102);
        misaligned("mis_half", 1, 2'd1, 32'h0000_0101);
        misaligned("mis_dbl", 0, 2'd3, 32'h0000_0100);

        access("stall_store", 1, 2'd2, 0, 32'h0000_0048, 32'h1122_3344,
               32'h0000_0048, 4'b1111, 32'h1122_3344, LONG_STALL, 0, 0, 0);

        // reset in the third stalled cycle abandons the read
        issue(0, 2'd2, 0, 32'h0000_0400, 32'h0, 1'b0, 32'h9999_9999);
        m_ready = 1'b0;
        check_req("rst_stall1", 0, 32'h0000_0400, 4'b1111, 32'h0);
        @(posedge clk); #1;
        m_rvalid = 1'b1; m_rdata = 32'h9999_9999;
        check_req("rst_stall2", 0, 32'h0000_0400, 4'b1111, 32'h0);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        check_req("rst_stall3", 0, 32'h0000_0400, 4'b1111, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_we", m_we, 0);
        check("arst_be", m_be, 0);
        check("arst_addr", m_addr, 0);
        check("arst_rdata", c_rdata, 0);
        sb.delete();
        exp_last = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_nodone", c_done, 0);
        end

        access("post_rst_lw", 0, 2'd2, 1, 32'h0000_0404, 32'h0,
               32'h0000_0404, 4'b1111, 32'h0, 0, 32'h0BAD_F00D, 3, 32'h0BAD_F00D);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        begin
            int cyc;
            // response never arrives: accepted at the first REQ edge, then starved in RESP
            issue(0, 2'd2, 0, 32'h0000_0500, 32'h0, 1'b1, 32'h0);
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
            cyc = 0;
            while (!c_done && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("to_resp_done", c_done, 1);
            check("to_resp_cycles", cyc, 3);
            check("to_resp_busy", busy, 0);
            @(posedge clk); #1;
            // never accepted: m_valid must drop after the limit
            issue(1, 2'd2, 0, 32'h0000_0600, 32'h1, 1'b1, 32'h0);
            cyc = 0;
            while (!c_done && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("to_req_done", c_done, 1);
            check("to_req_cycles", cyc, 4);
            check("to_req_valid", m_valid, 0);
            access("to_after", 0, 2'd2, 0, 32'h0000_0504, 32'h0,
                   32'h0000_0504, 4'b1111, 32'h0, 0, 32'h5A5A_5A5A, 2, 32'h5A5A_5A5A);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
